regs_wb_arb: RTL and testbench
==============================

REGS_WB_ARB -- requirements
Module: regs_wb_arb

Interface
REQ-001 The block SHALL have exactly these parameters: DEPTH, 2, number of entries in the MEM writeback buffer (legal values 2 or 4); XLEN, 32, width of register data.
REQ-002 The block SHALL have exactly these ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- rest  in  1  asynchronous active-high reset.
- ex_wb_en_i  in  1  EX-stage result valid this cycle; always accepted, never back-pressured.
- ex_rd_addr_i  in  5  EX destination register.
- ex_rd_data_i  in  XLEN  EX result.
- mem_valid_i  in  1  MEM-stage load result offered.
- mem_rd_i  in  5  MEM destination register.
- mem_data_i  in  XLEN  MEM load data.
- mem_ready_o  out  1  buffer can accept a MEM result.
- id_issue_en_i  in  1  ID issues an instruction this cycle.
- id_issue_load_i  in  1  issued instruction is a load.
- id_issue_rd_i  in  5  issued instruction destination.
- id_rs1_addr_i  in  5  ID source 1.
- id_rs2_addr_i  in  5  ID source 2.
- id_stall_o  out  1  a source register awaits an outstanding load.
- regs_wb_en_o  out  1  register-file write enable.
- regs_rd_addr_o  out  5  register-file write address.
- regs_rd_data_o  out  XLEN  register-file write data.

Function
REQ-003 The block SHALL drive regs_wb_en_o, regs_rd_addr_o and regs_rd_data_o from flops, so each write appears one cycle after its source is selected.
REQ-004 The block SHALL select at most one write source per cycle, in this priority order: EX (ex_wb_en_i=1 and ex_rd_addr_i!=0); buffer head; direct MEM (buffer empty and mem_valid_i=1).
REQ-005 A MEM transfer SHALL occur when mem_valid_i=1 and mem_ready_o=1.
REQ-006 mem_ready_o SHALL be 1 exactly when the buffer count is less than DEPTH.
REQ-007 A transferred MEM result SHALL be written directly only if the buffer is empty and no EX write is selected; otherwise it SHALL be pushed to the buffer.
REQ-008 The buffer SHALL be FIFO ordered, with push and pop permitted in the same cycle and the count unchanged when both occur.
REQ-009 A MEM result with rd=0 SHALL be accepted and discarded; it SHALL produce no write and no buffer entry.
REQ-010 An EX write with rd=0 SHALL be ignored.
REQ-011 Squash: on an accepted EX write to rd=R, every valid buffer entry with rd=R SHALL be marked squashed in the same cycle, because the EX write is younger.
REQ-012 A squashed entry SHALL be popped with priority equal to a live entry but SHALL drive regs_wb_en_o=0.
REQ-013 A MEM result directly matching the EX rd in the same cycle SHALL be treated as squashed.
REQ-014 Scoreboard: the block SHALL hold a 32-bit pending vector.
REQ-015 A pending bit SHALL be set on id_issue_en_i=1, id_issue_load_i=1 and id_issue_rd_i!=0.
REQ-016 A pending bit SHALL be cleared when a MEM result for that rd is written or popped squashed.
REQ-017 On a simultaneous set and clear of the same bit, set SHALL win.
REQ-018 Bit 0 SHALL never be set.
REQ-019 id_stall_o SHALL be combinational: pending[id_rs1_addr_i] OR pending[id_rs2_addr_i].
REQ-020 The block SHALL accept at most one EX write per cycle.

Reset
REQ-021 While rest=1 (asynchronous assertion) the block SHALL hold regs_wb_en_o=0, regs_rd_addr_o=0, regs_rd_data_o=0, buffer empty, all pending bits 0, mem_ready_o=0 and id_stall_o=0.
REQ-022 On reset mid-operation, buffered entries SHALL be discarded without being written.
REQ-023 After reset release the block SHALL assert mem_ready_o=1 in the first cycle.

Verification
REQ-024 Lone EX write: EX write x5=0x11 -> regs_wb_en_o=1, addr=5, data=0x11 one cycle later; no other write.
REQ-025 EX/MEM collision: EX x3=0xA and MEM x4=0xB in the same cycle -> x3 write at T+1, x4 write at T+2; mem_ready_o stays 1.
REQ-026 Back-pressure (DEPTH=2): EX active 3 consecutive cycles while MEM offers 3 results -> mem_ready_o=0 after 2 pushes; the 3rd MEM result is held and all writes emerge in order.
REQ-027 Squash: MEM x7=0x1 buffered, then EX x7=0x2 -> only 0x2 is written to x7; pending[7] cleared at the squashed pop.
REQ-028 Scoreboard: load issued to x9, ID reads rs1=9 -> id_stall_o=1 until the x9 MEM write is issued, then 0; a load to x0 never stalls.
REQ-029 Async reset: assert rest mid-stream with 2 entries buffered -> outputs 0 immediately, no buffered write after release.

Source files
------------

// File: rtl/regs_wb_arb.sv
`default_nettype none
// ============================================================================
// regs_wb_arb : EX/MEM register-file writeback arbiter with load scoreboard
// Rev 1.0
// ============================================================================
module regs_wb_arb #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            ex_wb_en_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic [XLEN-1:0] ex_rd_data_i,
  input  logic            mem_valid_i,
  input  logic [4:0]      mem_rd_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic            mem_ready_o,
  input  logic            id_issue_en_i,
  input  logic            id_issue_load_i,
  input  logic [4:0]      id_issue_rd_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  output logic            id_stall_o,
  output logic            regs_wb_en_o,
  output logic [4:0]      regs_rd_addr_o,
  output logic [XLEN-1:0] regs_rd_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW:0]     count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [4:0]      buf_rd   [DEPTH];
  logic [XLEN-1:0] buf_data [DEPTH];
  logic [DEPTH-1:0] buf_sq;
  logic [31:0]     pending, pending_nxt;

  logic            ex_sel, buf_empty, mem_xfer, mem_live;
  logic            pop, push, direct, push_sq, head_sq;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // Ready is forced low while reset is held, not just after the flops clear
  assign mem_ready_o = ~rest & (count < FULL);
  assign id_stall_o  = pending[id_rs1_addr_i] | pending[id_rs2_addr_i];

  always_comb begin
    ex_sel    = ex_wb_en_i & (ex_rd_addr_i != 5'd0);
    buf_empty = (count == '0);
    mem_xfer  = mem_valid_i & mem_ready_o;
    mem_live  = mem_xfer & (mem_rd_i != 5'd0);
    pop       = ~ex_sel & ~buf_empty;
    direct    = ~ex_sel & buf_empty & mem_live;
    push      = mem_live & ~direct;
    push_sq   = ex_sel & (mem_rd_i == ex_rd_addr_i);
    head_rd   = buf_rd[rd_ptr];
    head_data = buf_data[rd_ptr];
    head_sq   = buf_sq[rd_ptr];
  end

  // A same-cycle load issue to a register being retired keeps its pending bit
  always_comb begin
    pending_nxt = pending;
    if (direct)
      pending_nxt[mem_rd_i] = 1'b0;
    else if (pop)
      pending_nxt[head_rd] = 1'b0;
    if (id_issue_en_i & id_issue_load_i)
      pending_nxt[id_issue_rd_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)
        count <= count + 1'b1;
      else if (pop & ~push)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count alone defines which entries are valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ex_sel && (buf_rd[i] == ex_rd_addr_i))
        buf_sq[i] <= 1'b1;
    end
    if (push) begin
      buf_rd[wr_ptr]   <= mem_rd_i;
      buf_data[wr_ptr] <= mem_data_i;
      buf_sq[wr_ptr]   <= push_sq;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      regs_wb_en_o   <= 1'b0;
      regs_rd_addr_o <= '0;
      regs_rd_data_o <= '0;
    end else if (ex_sel) begin
      regs_wb_en_o   <= 1'b1;
      regs_rd_addr_o <= ex_rd_addr_i;
      regs_rd_data_o <= ex_rd_data_i;
    end else if (pop) begin
      regs_wb_en_o <= ~head_sq;
      if (!head_sq) begin
        regs_rd_addr_o <= head_rd;
        regs_rd_data_o <= head_data;
      end
    end else if (direct) begin
      regs_wb_en_o   <= 1'b1;
      regs_rd_addr_o <= mem_rd_i;
      regs_rd_data_o <= mem_data_i;
    end else begin
      regs_wb_en_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regs_wb_arb.sv
`default_nettype none
// ============================================================================
// tb_regs_wb_arb : table-driven bench for regs_wb_arb with a write scoreboard
// Rev 1.0
// ============================================================================
module tb_regs_wb_arb;

  logic        clk = 1'b0;
  logic        rest;
  logic        ex_wb_en_i;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_data_i;
  logic        mem_ready_o;
  logic        id_issue_en_i;
  logic        id_issue_load_i;
  logic [4:0]  id_issue_rd_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_stall_o;
  logic        regs_wb_en_o;
  logic [4:0]  regs_rd_addr_o;
  logic [31:0] regs_rd_data_o;

  regs_wb_arb #(.DEPTH(2), .XLEN(32)) dut (
    .clk            (clk),
    .rest           (rest),
    .ex_wb_en_i     (ex_wb_en_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .ex_rd_data_i   (ex_rd_data_i),
    .mem_valid_i    (mem_valid_i),
    .mem_rd_i       (mem_rd_i),
    .mem_data_i     (mem_data_i),
    .mem_ready_o    (mem_ready_o),
    .id_issue_en_i  (id_issue_en_i),
    .id_issue_load_i(id_issue_load_i),
    .id_issue_rd_i  (id_issue_rd_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_stall_o     (id_stall_o),
    .regs_wb_en_o   (regs_wb_en_o),
    .regs_rd_addr_o (regs_rd_addr_o),
    .regs_rd_data_o (regs_rd_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ex_en;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        ie;
    logic        il;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rdy;
    logic        stl;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mkv(logic ex_en, logic [4:0] ex_rd, logic [31:0] ex_data,
                               logic mv, logic [4:0] mrd, logic [31:0] mdata,
                               logic ie, logic il, logic [4:0] ird,
                               logic [4:0] rs1, logic [4:0] rs2,
                               logic rdy, logic stl,
                               logic wen, logic [4:0] wa, logic [31:0] wd);
    vec_t v;
    v.ex_en = ex_en; v.ex_rd = ex_rd; v.ex_data = ex_data;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.ie = ie; v.il = il; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.rdy = rdy; v.stl = stl; v.wen = wen; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_wb_en_i = 0; ex_rd_addr_i = 0; ex_rd_data_i = 0;
    mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
    id_issue_en_i = 0; id_issue_load_i = 0; id_issue_rd_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic apply(input vec_t v, input int idx);
    wr_t w;
    ex_wb_en_i = v.ex_en; ex_rd_addr_i = v.ex_rd; ex_rd_data_i = v.ex_data;
    mem_valid_i = v.mv; mem_rd_i = v.mrd; mem_data_i = v.mdata;
    id_issue_en_i = v.ie; id_issue_load_i = v.il; id_issue_rd_i = v.ird;
    id_rs1_addr_i = v.rs1; id_rs2_addr_i = v.rs2;
    #1;
    check($sformatf("v%0d mem_ready", idx), {31'd0, mem_ready_o}, {31'd0, v.rdy});
    check($sformatf("v%0d id_stall", idx), {31'd0, id_stall_o}, {31'd0, v.stl});
    sb.push_back('{wen: v.wen, wa: v.wa, wd: v.wd});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL v%0d scoreboard: got empty queue expected entry", idx);
    end else begin
      w = sb.pop_front();
      check($sformatf("v%0d wb_en", idx), {31'd0, regs_wb_en_o}, {31'd0, w.wen});
      if (w.wen) begin
        check($sformatf("v%0d wb_addr", idx), {27'd0, regs_rd_addr_o}, {27'd0, w.wa});
        check($sformatf("v%0d wb_data", idx), regs_rd_data_o, w.wd);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    //             ex  rd  data        mv mrd mdata       ie il ird rs1 rs2 rdy stl wen wa  wd
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));   // first cycle ready
    vecs.push_back(mkv(1, 5,  32'h11,  0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 1, 5,  32'h11));  // lone EX
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(1, 3,  32'hA,   1, 4,  32'hB,      0, 0, 0,  0,  0,  1, 0, 1, 3,  32'hA));   // collision
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 1, 4,  32'hB));
    vecs.push_back(mkv(1, 10, 32'h100, 1, 11, 32'h200,    0, 0, 0,  0,  0,  1, 0, 1, 10, 32'h100)); // back-pressure
    vecs.push_back(mkv(1, 12, 32'h101, 1, 13, 32'h201,    0, 0, 0,  0,  0,  1, 0, 1, 12, 32'h101));
    vecs.push_back(mkv(1, 14, 32'h102, 1, 15, 32'h202,    0, 0, 0,  0,  0,  0, 0, 1, 14, 32'h102));
    vecs.push_back(mkv(0, 0,  32'h0,   1, 15, 32'h202,    0, 0, 0,  0,  0,  0, 0, 1, 11, 32'h200));
    vecs.push_back(mkv(0, 0,  32'h0,   1, 15, 32'h202,    0, 0, 0,  0,  0,  1, 0, 1, 13, 32'h201));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 1, 15, 32'h202));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      1, 1, 7,  0,  0,  1, 0, 0, 0,  32'h0));   // squash
    vecs.push_back(mkv(1, 2,  32'h33,  1, 7,  32'h1,      0, 0, 0,  7,  0,  1, 1, 1, 2,  32'h33));
    vecs.push_back(mkv(1, 7,  32'h2,   0, 0,  32'h0,      0, 0, 0,  7,  0,  1, 1, 1, 7,  32'h2));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  7,  0,  1, 1, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  7,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      1, 1, 9,  9,  0,  1, 0, 0, 0,  32'h0));   // scoreboard
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  9,  0,  1, 1, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   1, 9,  32'h99,     0, 0, 0,  0,  9,  1, 1, 1, 9,  32'h99));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  9,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      1, 1, 0,  0,  0,  1, 0, 0, 0,  32'h0));   // load to x0
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      1, 1, 6,  0,  0,  1, 0, 0, 0,  32'h0));   // set beats clear
    vecs.push_back(mkv(0, 0,  32'h0,   1, 6,  32'h66,     1, 1, 6,  6,  0,  1, 1, 1, 6,  32'h66));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  6,  0,  1, 1, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   1, 6,  32'h67,     0, 0, 0,  6,  0,  1, 1, 1, 6,  32'h67));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  6,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   1, 0,  32'h55,     0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));   // MEM rd=0
    vecs.push_back(mkv(1, 1,  32'h7,   1, 0,  32'h56,     0, 0, 0,  0,  0,  1, 0, 1, 1,  32'h7));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(1, 0,  32'hFF,  0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));   // EX rd=0
    vecs.push_back(mkv(1, 8,  32'h80,  1, 8,  32'h81,     0, 0, 0,  0,  0,  1, 0, 1, 8,  32'h80));  // same-cycle match
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(0, 0,  32'h0,   0, 0,  32'h0,      0, 0, 0,  0,  0,  1, 0, 0, 0,  32'h0));
    vecs.push_back(mkv(1, 20, 32'h1,   1, 21, 32'h2,      0, 0, 0,  0,  0,  1, 0, 1, 20, 32'h1));   // fill before reset
    vecs.push_back(mkv(1, 22, 32'h3,   1, 23, 32'h4,      1, 1, 25, 0,  0,  1, 0, 1, 22, 32'h3));

    clear_inputs();
    rest = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset wb_en", {31'd0, regs_wb_en_o}, 32'd0);
    check("reset wb_addr", {27'd0, regs_rd_addr_o}, 32'd0);
    check("reset wb_data", regs_rd_data_o, 32'd0);
    check("reset mem_ready", {31'd0, mem_ready_o}, 32'd0);
    check("reset id_stall", {31'd0, id_stall_o}, 32'd0);
    rest = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Asynchronous reset with two entries buffered and x25 pending
    clear_inputs();
    id_rs1_addr_i = 5'd25;
    #2;
    rest = 1'b1;
    #1;
    check("async wb_en", {31'd0, regs_wb_en_o}, 32'd0);
    check("async wb_addr", {27'd0, regs_rd_addr_o}, 32'd0);
    check("async wb_data", regs_rd_data_o, 32'd0);
    check("async mem_ready", {31'd0, mem_ready_o}, 32'd0);
    check("async id_stall", {31'd0, id_stall_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rest = 1'b0;
    for (int i = 0; i < 3; i++)
      apply(mkv(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 25, 0, 1, 0, 0, 0, 32'h0), 100 + i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
